// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 16-bit ALU: accepts ops, waits ALU_LAT cycles,
// queues {result, err, tag} in an in-order FWFT response FIFO.
// Ports: clk/reset, cmd_* (valid/ready in), alu_* (to/from ALU),
// rsp_* (valid/ready out), err_cnt (saturating error count).
module alu_cmd_sequencer #(
  parameter int W       = 16,
  parameter int ALU_LAT = 1,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_sel,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_busy,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [7:0]       err_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       state;
  logic [3:0]       wait_cnt;
  logic [TAG_W-1:0] tag_q;

  logic [W-1:0]     mem_data [DEPTH];
  logic             mem_err  [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic accept;
  logic push;
  logic pop;

  assign cmd_ready = !reset && (state == S_IDLE)
                   && (count < (AW+1)'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == S_WAIT) && (wait_cnt == 4'd1);

  assign rsp_valid = !reset && (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Head is gated so the outputs read zero under reset / when empty.
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_err   = rsp_valid ? mem_err[rd_ptr]  : 1'b0;
  assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      tag_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      alu_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
            alu_sel  <= cmd_sel;
            tag_q    <= cmd_tag;
            wait_cnt <= 4'(ALU_LAT);
            alu_busy <= 1'b1;
            state    <= S_WAIT;
          end
        end
        default: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (push) begin
            alu_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (alu_err && (err_cnt != 8'hff))
          err_cnt <= err_cnt + 8'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only visible while count != 0.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_data[wr_ptr] <= alu_out;
      mem_err[wr_ptr]  <= alu_err;
      mem_tag[wr_ptr]  <= tag_q;
    end
  end

endmodule
